mult_stream_adapter: RTL and testbench
======================================

# mult_stream_adapter

Valid/ready front-end for the iterative Booth multiplier core. It sits directly upstream of the core: it accepts signed operand pairs from a streaming producer and issues a one-cycle start pulse to the core. It waits for the core's done, captures the product into a small output FIFO, and presents results on a valid/ready stream. It keeps exactly one operation in flight and detects a hung core with a timeout.

## Interface
- N, default 64: operand width; must match the core's N.
- OUT_DEPTH, default 2: output FIFO depth; power of two, ≥2.
- clk  in  1: clock; one clock domain.
- rst  in  1: reset, synchronous, active-high.
- in_valid  in  1: operand pair valid.
- in_ready  out  1: adapter accepts the pair this cycle.
- in_a  in  N: signed multiplicand.
- in_b  in  N: signed multiplier.
- mul_start  out  1: one-cycle start pulse to the core.
- mul_multiplicand  out  N: registered in_a, held stable from accept until next accept.
- mul_multiplier  out  N: registered in_b, same hold rule.
- mul_product  in  2N: core product, valid while mul_done=1.
- mul_done  in  1: core done; sticky high, cleared by the core on the edge that samples start.
- out_valid  out  1: FIFO non-empty.
- out_ready  in  1: consumer accepts the head.
- out_product  out  2N: FIFO head, signed.
- busy  out  1: state ≠ IDLE.
- err  out  1: sticky timeout flag.

## Operation
- FSM states: IDLE, START, WAIT, CAPTURE.
- IDLE: in_ready = (fifo_count < OUT_DEPTH). On in_valid&&in_ready, latch in_a and in_b, then go to START.
- START: mul_start=1 for exactly this cycle. Clear wait_cnt, then go to WAIT.
- WAIT: increment wait_cnt each cycle.
  - If mul_done=1, go to CAPTURE.
  - Else if wait_cnt reaches TIMEOUT = N+8, set err, discard the operation, and go to IDLE.
- CAPTURE: push mul_product into the FIFO, then go to IDLE.
- mul_done is ignored outside WAIT. In WAIT it is always fresh, because the core cleared it on the START edge.
- Space reservation: in_ready is gated on FIFO space at accept time. Only pops occur until CAPTURE, so the push never meets a full FIFO. An overflow push is a design error and must never occur.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged.
  - Pop only when out_valid&&out_ready.
  - Pointers wrap modulo OUT_DEPTH.
  - Head data is stable while out_valid&&!out_ready.
- Products pass through unmodified: 2N bits, two's complement; no saturation or truncation.
- err stays set until rst. The adapter keeps operating after a timeout.
- Reset values: in_ready=0 during rst, then per rule; mul_start=0; mul_multiplicand=0; mul_multiplier=0; out_valid=0; out_product=0; busy=0; err=0; FIFO empty; state IDLE; wait_cnt=0.
- Reset mid-operation: the operation in flight and FIFO contents are discarded, and no result emerges. The same rst also resets the core.

## Timing
- Input accept in cycle 0 → mul_start high in cycle 1.
- Core: N shift edges, then done registered; mul_done is first visible in cycle N+3.
- CAPTURE in cycle N+3 (the WAIT cycle that sees done transitions) → push at end of cycle N+4 → out_valid in cycle N+5 when the FIFO was empty.
- Latency from accept to out_valid: N+5 cycles. Re-accept is possible in cycle N+5 (IDLE).
- Throughput: one op per N+5 cycles when out_ready=1.
- mul_start is never high on two consecutive cycles.
- All outputs are registered, except in_ready, which is combinational from state and fifo_count.

## Structure
- Package mult_pkg holds:
  - state enum typedef (IDLE, START, WAIT, CAPTURE);
  - timeout margin constant (8);
  - function timeout_cycles(N) = N+8.
- Sub-module sync_fifo (parameters WIDTH and DEPTH; synchronous reset; push, pop, full, empty, count), instantiated with WIDTH=2N and DEPTH=OUT_DEPTH.
- The FSM, operand registers and timeout counter live in the top module.
- Bench instantiates the adapter with the real core, N=8.

## Test plan
- Single op, N=8: a=3, b=-5, out_ready=1 → out_product=0xFFF1 (−15), with out_valid first high 13 cycles after accept; mul_start is a single-cycle pulse.
- Corner operands: (−128, −128) → 0x4000; (127, −128) → 0xC080; (0, −1) → 0x0000; back-to-back results arrive in order.
- Backpressure, OUT_DEPTH=2, out_ready=0: two ops complete, and in_ready stays 0 with the FIFO full. A third pair is held until one pop, then accepted on the next IDLE cycle. No data is lost and head data stays stable while stalled.
- Simultaneous push and pop: release out_ready in the same cycle as CAPTURE's push → fifo_count unchanged and ordering correct.
- Timeout: replace the core with a stub that never raises done → err=1 exactly TIMEOUT cycles into WAIT, busy=0 next cycle, no out_valid. A following op with the real core completes normally with err still 1.
- Reset mid-op: assert rst in WAIT, cycle 5 → next cycle all outputs at reset values, FIFO empty, no stale product emitted, and a fresh op succeeds.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and timeout constants for the multiplier stream adapter.
// No ports; imported by mult_stream_adapter.
package mult_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_e;
   localparam int TIMEOUT_MARGIN = 8;
   function automatic int timeout_cycles(input int n);
      return n + TIMEOUT_MARGIN;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and occupancy count.
// Ports: clk, rst (sync, active-high); push_i/data_i write side; pop_i read side;
// data_o is the head entry; full_o, empty_o and count_o report occupancy.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;
   assign full_o  = count_q == CW'(DEPTH);
   assign empty_o = count_q == '0;
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/mult_stream_adapter.sv
// mult_stream_adapter: valid/ready front-end that feeds one operand pair at a time to the
// iterative Booth core and streams the products out through a small FIFO.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b operand stream;
// mul_start/mul_multiplicand/mul_multiplier/mul_product/mul_done core handshake;
// out_valid/out_ready/out_product result stream; busy (not idle); err (sticky core timeout).
module mult_stream_adapter
   import mult_pkg::*;
#(
   parameter int N         = 64,
   parameter int OUT_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   output logic             mul_start,
   output logic [N-1:0]     mul_multiplicand,
   output logic [N-1:0]     mul_multiplier,
   input  logic [2*N-1:0]   mul_product,
   input  logic             mul_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_product,
   output logic             busy,
   output logic             err
);
   localparam int TIMEOUT = timeout_cycles(N);
   localparam int WW      = $clog2(TIMEOUT + 1);
   localparam int CW      = $clog2(OUT_DEPTH) + 1;
   state_e        state_q, state_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic [N-1:0]  a_q, b_q;
   logic          start_q, err_q, accept, timeout_hit, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   // Accepting only with a free FIFO slot reserves room for the eventual capture.
   assign in_ready         = !rst && state_q == IDLE && fifo_count < CW'(OUT_DEPTH);
   assign accept           = in_valid && in_ready;
   assign timeout_hit      = state_q == WAIT && !mul_done && wait_cnt_q == WW'(TIMEOUT - 1);
   assign mul_start        = start_q;
   assign mul_multiplicand = a_q;
   assign mul_multiplier   = b_q;
   assign busy             = state_q != IDLE;
   assign err              = err_q;
   assign out_valid        = !fifo_empty;
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         IDLE:    state_d = accept ? START : IDLE;
         START: begin
            wait_cnt_d = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + WW'(1);
            state_d    = mul_done ? CAPTURE : timeout_hit ? IDLE : WAIT;
         end
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         start_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
         end
         start_q <= accept;
         err_q   <= err_q | timeout_hit;
      end
   end
   sync_fifo #(.WIDTH(2 * N), .DEPTH(OUT_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (state_q == CAPTURE && !fifo_full),
      .pop_i   (out_valid && out_ready),
      .data_i  (mul_product),
      .data_o  (out_product),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );
endmodule

// File: tb/tb_mult_stream_adapter.sv
// tb_mult_stream_adapter: self-checking bench for the adapter driving a behavioural Booth core, N=8.
module tb_mult_stream_adapter;
   localparam int N = 8;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, out_ready = 1'b0;
   logic [7:0]  in_a = '0, in_b = '0, mul_multiplicand, mul_multiplier;
   logic        mul_start, mul_done, out_valid, busy, err;
   logic [15:0] mul_product, out_product;
   int          checks = 0, failures = 0, cyc = 0;
   logic [15:0] exp_q[$];
   logic        stub = 1'b0;
   logic [7:0]  core_a, core_b;
   logic [3:0]  core_cnt;
   logic        core_done;
   logic [15:0] core_prod;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_stream_adapter #(.N(N), .OUT_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
      .mul_product(mul_product), .mul_done(mul_done), .out_valid(out_valid), .out_ready(out_ready),
      .out_product(out_product), .busy(busy), .err(err)
   );

   // Core: N shift edges after the start edge, then done registered; stub suppresses done.
   always_ff @(posedge clk) begin
      if (rst) begin
         core_cnt <= '0; core_done <= 1'b0; core_prod <= '0; core_a <= '0; core_b <= '0;
      end else if (mul_start) begin
         core_cnt <= 4'(N + 1); core_done <= 1'b0; core_a <= mul_multiplicand; core_b <= mul_multiplier;
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 4'd1;
         if (core_cnt == 4'd1 && !stub) begin
            core_done <= 1'b1;
            core_prod <= $signed(core_a) * $signed(core_b);
         end
      end
   end
   assign mul_done    = core_done;
   assign mul_product = core_prod;

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
      int pa, pb;
      pa = $signed(a);
      pb = $signed(b);
      return 16'(pa * pb);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, output int acc);
      in_a = a; in_b = b; in_valid = 1'b1; acc = -1;
      for (int i = 0; i < 200 && acc < 0; i++) begin
         if (in_ready) acc = cyc;
         tick();
      end
      in_valid = 1'b0;
      if (acc >= 0) exp_q.push_back(model(a, b));
   endtask

   task automatic get_out(input int max, output logic [15:0] p, output int at);
      at = -1; p = 'x;
      for (int i = 0; i < max; i++) begin
         if (out_valid && out_ready) begin
            p = out_product; at = cyc;
            tick();
            return;
         end
         tick();
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!busy) return;
         tick();
      end
   endtask

   function automatic logic [15:0] pop_exp();
      return exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      rst = 1'b0; #1;
      checks++;
      if ({mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got start=%b a=%h b=%h ov=%b prod=%h busy=%b err=%b exp all zero",
                  mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, err);
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_single();
      int acc, at;
      logic [15:0] p, e;
      out_ready = 1'b1;
      send(8'd3, 8'hFB, acc);
      checks++; if (mul_start !== 1'b1) begin failures++; $display("FAIL start_pulse_high got=%b exp=1", mul_start); end
      tick();
      checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL start_pulse_low got=%b exp=0", mul_start); end
      get_out(40, p, at);
      e = pop_exp();
      checks++; if (p !== e) begin failures++; $display("FAIL single_product got=%h exp=%h", p, e); end
      checks++; if (at - acc != 13) begin failures++; $display("FAIL single_latency got=%0d exp=13", at - acc); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ca[3], cb[3];
      logic [15:0] got[3], e;
      int          at[3], acc;
      ca = '{8'h80, 8'h7F, 8'h00};
      cb = '{8'h80, 8'h80, 8'hFF};
      out_ready = 1'b1;
      fork
         begin for (int i = 0; i < 3; i++) send(ca[i], cb[i], acc); end
         begin for (int j = 0; j < 3; j++) get_out(80, got[j], at[j]); end
      join
      for (int k = 0; k < 3; k++) begin
         e = pop_exp();
         checks++; if (got[k] !== e) begin failures++; $display("FAIL corner_product_%0d got=%h exp=%h", k, got[k], e); end
      end
      checks++;
      if (at[1] - at[0] != 13 || at[2] - at[1] != 13) begin
         failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=13,13", at[1] - at[0], at[2] - at[1]);
      end
   endtask

   task automatic test_backpressure();
      int acc, at;
      logic [15:0] head, p, e;
      logic stall_ok;
      out_ready = 1'b0;
      send(8'd7, 8'd9, acc); wait_idle();
      send(8'hF0, 8'd3, acc); wait_idle();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got ov=%b ir=%b exp ov=1 ir=0", out_valid, in_ready); end
      head = out_product;
      in_a = 8'h11; in_b = 8'hEE; in_valid = 1'b1; stall_ok = 1'b1;
      repeat (5) begin
         tick();
         if (in_ready !== 1'b0 || busy !== 1'b0 || out_product !== head) stall_ok = 1'b0;
      end
      checks++; if (stall_ok !== 1'b1) begin failures++; $display("FAIL bp_stall got ok=%b exp=1", stall_ok); end
      e = pop_exp();
      checks++; if (head !== e) begin failures++; $display("FAIL bp_head got=%h exp=%h", head, e); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_reaccept got=%b exp=1", in_ready); end
      checks++; if (out_product !== exp_q[0]) begin failures++; $display("FAIL bp_next_head got=%h exp=%h", out_product, exp_q[0]); end
      exp_q.push_back(model(8'h11, 8'hEE));
      tick();
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_third_busy got=%b exp=1", busy); end
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         get_out(40, p, at);
         e = pop_exp();
         checks++; if (p !== e) begin failures++; $display("FAIL bp_drain_%0d got=%h exp=%h", i, p, e); end
      end
   endtask

   task automatic test_simul();
      int acc;
      logic [15:0] p, e;
      out_ready = 1'b0;
      send(8'd2, 8'd2, acc); wait_idle();
      send(8'hFF, 8'd5, acc);
      while (cyc < acc + 12) tick();
      checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL simul_pre got busy=%b ov=%b exp 1,1", busy, out_valid); end
      out_ready = 1'b1; p = out_product;
      tick();
      out_ready = 1'b0;
      e = pop_exp();
      checks++; if (p !== e) begin failures++; $display("FAIL simul_first got=%h exp=%h", p, e); end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL simul_count got ov=%b ir=%b busy=%b exp 1,1,0", out_valid, in_ready, busy); end
      p = out_product; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      e = pop_exp();
      checks++; if (p !== e) begin failures++; $display("FAIL simul_second got=%h exp=%h", p, e); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_timeout();
      int acc, at;
      logic [15:0] p, e;
      logic seen;
      stub = 1'b1; out_ready = 1'b1; seen = 1'b0;
      send(8'd5, 8'd6, acc);
      exp_q.delete();
      while (cyc < acc + 17) begin seen |= out_valid; tick(); end
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL timeout_early got err=%b busy=%b exp 0,1", err, busy); end
      tick();
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_fire got err=%b busy=%b exp 1,0", err, busy); end
      checks++; if (seen !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL timeout_no_output got=%b exp=0", seen | out_valid); end
      stub = 1'b0;
      send(8'hFA, 8'h0B, acc);
      get_out(40, p, at);
      e = pop_exp();
      checks++; if (p !== e) begin failures++; $display("FAIL timeout_recover got=%h exp=%h", p, e); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", err); end
   endtask

   task automatic test_reset_midop();
      int acc, at;
      logic [15:0] p, e;
      logic seen;
      out_ready = 1'b0;
      send(8'd4, 8'd4, acc); wait_idle();
      send(8'h81, 8'h02, acc);
      while (cyc < acc + 5) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({in_ready, mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, err} !== '0) begin
         failures++;
         $display("FAIL midop_reset got ir=%b start=%b a=%h b=%h ov=%b prod=%h busy=%b err=%b exp all zero",
                  in_ready, mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, err);
      end
      rst = 1'b0; exp_q.delete(); out_ready = 1'b1; seen = 1'b0;
      repeat (20) begin tick(); seen |= out_valid; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midop_stale got=%b exp=0", seen); end
      send(8'h9C, 8'h64, acc);
      get_out(40, p, at);
      e = pop_exp();
      checks++; if (p !== e) begin failures++; $display("FAIL midop_fresh got=%h exp=%h", p, e); end
      checks++; if (at - acc != 13) begin failures++; $display("FAIL midop_latency got=%0d exp=13", at - acc); end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_simul();
      test_timeout();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
